// File: rtl/adder_arbiter.sv
// adder_arbiter: four requesters share one registered WL-bit unsigned adder (WL+1-bit sum).
// Latency: grant one cycle after the request is seen; odone and odata follow two cycles after it; one operation per 3 cycles.
// No backpressure: a requester holds ireq until its odone. Defining ADDER_ARBITER_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module adder_arbiter #(
    parameter int WL = 4
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic [3:0]      ireq,
    input  logic [4*WL-1:0] idata1,
    input  logic [4*WL-1:0] idata2,
    output logic [3:0]      ogrant,
    output logic [3:0]      odone,
    output logic [WL:0]     odata,
    output logic            obusy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          win_vld;
    logic [1:0]    win_idx;
    logic [1:0]    sel;
    logic [WL-1:0] opa;
    logic [WL-1:0] opb;

`ifdef ADDER_ARBITER_FIXED_PRIO_EN
    // Scanning from the top down leaves the lowest requesting index as winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (ireq[k]) begin
                win_vld = 1'b1;
                win_idx = 2'(k);
            end
        end
    end
`else
    logic [1:0] ptr;
    logic [1:0] cand;

    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!win_vld && ireq[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // The served requester drops to lowest priority once its operation retires.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            ptr <= 2'd0;
        end else if (state == DONE) begin
            ptr <= sel + 2'd1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign opa   = idata1[sel*WL +: WL];
    assign opb   = idata2[sel*WL +: WL];
    assign obusy = (state != IDLE);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            ogrant <= 4'b0000;
            odone  <= 4'b0000;
            odata  <= '0;
            sel    <= 2'd0;
        end else begin
            odone <= 4'b0000;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        sel    <= win_idx;
                        ogrant <= 4'b0001 << win_idx;
                    end
                end
                EXEC: begin
                    odata <= {1'b0, opa} + {1'b0, opb};
                    odone <= ogrant;
                end
                default: ogrant <= 4'b0000;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised self-checking bench for adder_arbiter against a transaction-level arbitration/sum model.
module tb_adder_arbiter;
    localparam int WL = 4;

    logic            iCLK = 1'b0;
    logic            iRST;
    logic [3:0]      ireq;
    logic [4*WL-1:0] idata1;
    logic [4*WL-1:0] idata2;
    logic [3:0]      ogrant;
    logic [3:0]      odone;
    logic [WL:0]     odata;
    logic            obusy;

    int nchecks = 0;
    int nerrors = 0;
    int ptr_m   = 0;
    int odata_m = 0;
    int op1[4];
    int op2[4];

    adder_arbiter #(.WL(WL)) dut (
        .iCLK(iCLK), .iRST(iRST), .ireq(ireq), .idata1(idata1), .idata2(idata2),
        .ogrant(ogrant), .odone(odone), .odata(odata), .obusy(obusy)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", nchecks, nerrors);
        $fatal(1);
    end

    function automatic int model_winner(input logic [3:0] req, input int p);
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (req[i]) return i;
`else
        for (int k = 0; k < 4; k++) if (req[(p + k) % 4]) return (p + k) % 4;
`endif
        return -1;
    endfunction

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < 4; i++) begin
            idata1[i*WL +: WL] = WL'(op1[i]);
            idata2[i*WL +: WL] = WL'(op2[i]);
        end
    endtask

    // Runs one operation starting in an IDLE cycle with ireq/operands already driven.
    task automatic do_txn(input string tag, input bit jitter);
        int w;
        int s;
        logic [13:0] got;
        logic [13:0] exp;
        w = model_winner(ireq, ptr_m);
        if (w < 0) begin
            nchecks++; nerrors++;
            $display("FAIL %s: transaction started with no request", tag);
            return;
        end
        step();
        got = {obusy, ogrant, odone, odata};
        exp = {1'b1, 4'(1 << w), 4'b0000, 5'(odata_m)};
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s exec {busy,grant,done,data}: got %h expected %h", tag, got, exp);
        end
        if (jitter) begin
            ireq = 4'($urandom_range(0, 15)) | 4'(1 << w);
            for (int i = 0; i < 4; i++) begin
                if (i != w) begin
                    op1[i] = $urandom_range(0, 15);
                    op2[i] = $urandom_range(0, 15);
                end
            end
            drive_ops();
        end
        step();
        s = op1[w] + op2[w];
        odata_m = s;
        got = {obusy, ogrant, odone, odata};
        exp = {1'b1, 4'(1 << w), 4'(1 << w), 5'(s)};
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s done {busy,grant,done,data}: got %h expected %h", tag, got, exp);
        end
        step();
        got = {obusy, ogrant, odone, odata};
        exp = {1'b0, 4'b0000, 4'b0000, 5'(odata_m)};
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s retire {busy,grant,done,data}: got %h expected %h", tag, got, exp);
        end
        ptr_m = (w + 1) % 4;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        ireq = 4'b0000;
        for (int i = 0; i < 4; i++) begin op1[i] = 0; op2[i] = 0; end
        drive_ops();
        #1;
        nchecks++;
        if ({obusy, ogrant, odone, odata} !== 14'd0) begin
            nerrors++;
            $display("FAIL reset_async: got %h expected 0", {obusy, ogrant, odone, odata});
        end
        step();
        iRST = 1'b0;
        step();
        nchecks++;
        if ({obusy, ogrant, odone, odata} !== 14'd0) begin
            nerrors++;
            $display("FAIL reset_release: got %h expected 0", {obusy, ogrant, odone, odata});
        end
        ptr_m   = 0;
        odata_m = 0;
    endtask

    task automatic test_single();
        op1[0] = 9; op2[0] = 7;
        drive_ops();
        ireq = 4'b0001;
        do_txn("single_req0", 1'b0);
        nchecks++;
        if (odata !== 5'd16) begin
            nerrors++;
            $display("FAIL single_sum: got %0d expected 16", odata);
        end
        ireq = 4'b0000;
    endtask

    task automatic test_round_robin();
        test_reset();
        for (int i = 0; i < 4; i++) begin op1[i] = i; op2[i] = 15; end
        drive_ops();
        ireq = 4'b1111;
        for (int n = 0; n < 5; n++) do_txn($sformatf("rr_%0d", n), 1'b0);
        ireq = 4'b0000;
    endtask

    task automatic test_max();
        op1[1] = 15; op2[1] = 15;
        drive_ops();
        ireq = 4'b0010;
        do_txn("max_sum", 1'b0);
        nchecks++;
        if (odata !== 5'd30) begin
            nerrors++;
            $display("FAIL max_no_trunc: got %0d expected 30", odata);
        end
        ireq = 4'b0000;
    endtask

    task automatic test_reset_mid();
        op1[2] = 4; op2[2] = 4;
        drive_ops();
        ireq = 4'b0100;
        step();
        nchecks++;
        if (ogrant !== 4'b0100) begin
            nerrors++;
            $display("FAIL rstmid_grant: got %b expected 0100", ogrant);
        end
        iRST = 1'b1;
        #1;
        nchecks++;
        if ({obusy, ogrant, odone, odata} !== 14'd0) begin
            nerrors++;
            $display("FAIL rstmid_async: got %h expected 0", {obusy, ogrant, odone, odata});
        end
        step();
        nchecks++;
        if ({obusy, ogrant, odone, odata} !== 14'd0) begin
            nerrors++;
            $display("FAIL rstmid_hold: got %h expected 0", {obusy, ogrant, odone, odata});
        end
        iRST = 1'b0;
        ptr_m = 0;
        odata_m = 0;
        op1[1] = 3; op2[1] = 12;
        drive_ops();
        ireq = 4'b0110;
        do_txn("rstmid_after", 1'b0);
        ireq = 4'b0000;
    endtask

    task automatic test_drop();
        op1[3] = 5; op2[3] = 6;
        drive_ops();
        ireq = 4'b1000;
        step();
        nchecks++;
        if (ogrant !== 4'b1000) begin
            nerrors++;
            $display("FAIL drop_grant: got %b expected 1000", ogrant);
        end
        ireq = 4'b0001;
        op1[0] = 2; op2[0] = 3;
        drive_ops();
        step();
        nchecks++;
        if ({ogrant, odone, odata} !== {4'b1000, 4'b1000, 5'd11}) begin
            nerrors++;
            $display("FAIL drop_done {grant,done,data}: got %h expected %h", {ogrant, odone, odata}, {4'b1000, 4'b1000, 5'd11});
        end
        step();
        nchecks++;
        if ({ogrant, odone} !== 8'h00) begin
            nerrors++;
            $display("FAIL drop_retire {grant,done}: got %h expected 00", {ogrant, odone});
        end
        ptr_m = 0;
        odata_m = 11;
        do_txn("drop_next_req0", 1'b0);
        ireq = 4'b0000;
    endtask

    task automatic test_idle();
        ireq = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            step();
            nchecks++;
            if ({obusy, ogrant, odone, odata} !== {1'b0, 8'h00, 5'(odata_m)}) begin
                nerrors++;
                $display("FAIL idle_%0d: got %h expected %h", c, {obusy, ogrant, odone, odata}, {1'b0, 8'h00, 5'(odata_m)});
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                op1[i] = $urandom_range(0, 15);
                op2[i] = $urandom_range(0, 15);
            end
            drive_ops();
            ireq = 4'($urandom_range(1, 15));
            do_txn($sformatf("rand_%0d", n), 1'b1);
        end
        ireq = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_max();
        test_reset_mid();
        test_drop();
        test_idle();
        test_random();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
